ex_operand_ctrl: RTL and testbench

//  Decode-to-execute operand controller: a one-entry pipeline register between ID and EX.

---
 rtl/ex_operand_ctrl.sv | 127 ++++++++++++
 tb/tb_ex_operand_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_ctrl.sv
// ex_operand_ctrl: ID->EX operand register with imm_sel decode, MEM/WB forwarding, WB snoop and load-use bubble.
// Define OPCTRL_TRACE_EN to add trace_imm_out/trace_fwd_out debug ports.
module ex_operand_ctrl #(
    parameter int XLEN       = 32,
    parameter int IMM_W      = 12,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  flush_in,
    input  logic                  id_valid_in,
    output logic                  id_ready_out,
    input  logic [6:0]            opcode_in,
    input  logic [REG_ADDR_W-1:0] rs1_addr_in,
    input  logic [REG_ADDR_W-1:0] rs2_addr_in,
    input  logic [REG_ADDR_W-1:0] rd_addr_in,
    input  logic [IMM_W-1:0]      imm_in,
    input  logic [XLEN-1:0]       rs1_data_in,
    input  logic [XLEN-1:0]       rs2_data_in,
    input  logic                  mem_wr_en_in,
    input  logic [REG_ADDR_W-1:0] mem_rd_in,
    input  logic [XLEN-1:0]       mem_result_in,
    input  logic                  wb_wr_en_in,
    input  logic [REG_ADDR_W-1:0] wb_rd_in,
    input  logic [XLEN-1:0]       wb_result_in,
    output logic                  ex_valid_out,
    input  logic                  ex_ready_in,
    output logic                  imm_sel_out,
    output logic [IMM_W-1:0]      imm_value_out,
    output logic [XLEN-1:0]       op_a_out,
    output logic [XLEN-1:0]       rs2_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  is_load_out,
`ifdef OPCTRL_TRACE_EN
    output logic                  illegal_out,
    output logic [IMM_W-1:0]      trace_imm_out,
    output logic [3:0]            trace_fwd_out
`else
    output logic                  illegal_out
`endif
);
    function automatic logic dec_imm(input logic [6:0] op);
        return op == 7'b0010011 || op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100111;
    endfunction

    function automatic logic dec_legal(input logic [6:0] op);
        return dec_imm(op) || op == 7'b0110011 || op == 7'b1100011;
    endfunction

    logic                  lu_cnt;
    logic [REG_ADDR_W-1:0] lu_rd, rs1_q, rs2_q;
    logic                  id_imm, lu_block, accept, fire;
    logic                  rs1_mem, rs1_wb, rs2_mem, rs2_wb, snoop1, snoop2;
    logic [XLEN-1:0]       rs1_fwd, rs2_fwd;

    always_comb begin
        id_imm       = dec_imm(opcode_in);
        lu_block     = lu_cnt && (rs1_addr_in == lu_rd || (!id_imm && rs2_addr_in == lu_rd));
        id_ready_out = !rst_in && (!ex_valid_out || ex_ready_in) && !lu_block && !flush_in;
        accept       = id_valid_in && id_ready_out;
        fire         = ex_valid_out && ex_ready_in;
        rs1_mem      = mem_wr_en_in && mem_rd_in == rs1_addr_in && |rs1_addr_in;
        rs1_wb       = !rs1_mem && wb_wr_en_in && wb_rd_in == rs1_addr_in && |rs1_addr_in;
        rs2_mem      = mem_wr_en_in && mem_rd_in == rs2_addr_in && |rs2_addr_in;
        rs2_wb       = !rs2_mem && wb_wr_en_in && wb_rd_in == rs2_addr_in && |rs2_addr_in;
        rs1_fwd      = !(|rs1_addr_in) ? '0 : rs1_mem ? mem_result_in : rs1_wb ? wb_result_in : rs1_data_in;
        rs2_fwd      = !(|rs2_addr_in) ? '0 : rs2_mem ? mem_result_in : rs2_wb ? wb_result_in : rs2_data_in;
        // a stalled entry must still see register writes retiring past it
        snoop1       = ex_valid_out && !ex_ready_in && wb_wr_en_in && wb_rd_in == rs1_q && |rs1_q;
        snoop2       = ex_valid_out && !ex_ready_in && wb_wr_en_in && wb_rd_in == rs2_q && |rs2_q;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ex_valid_out  <= 1'b0;
            imm_sel_out   <= 1'b0;
            imm_value_out <= '0;
            op_a_out      <= '0;
            rs2_out       <= '0;
            rd_out        <= '0;
            is_load_out   <= 1'b0;
            illegal_out   <= 1'b0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            lu_rd         <= '0;
            lu_cnt        <= 1'b0;
        end else if (flush_in) begin
            ex_valid_out <= 1'b0;
            lu_cnt       <= 1'b0;
        end else begin
            lu_cnt <= fire && is_load_out && |rd_out;
            if (fire && is_load_out && |rd_out)
                lu_rd <= rd_out;
            if (accept) begin
                ex_valid_out  <= 1'b1;
                imm_sel_out   <= id_imm;
                imm_value_out <= imm_in;
                op_a_out      <= rs1_fwd;
                rs2_out       <= rs2_fwd;
                rd_out        <= rd_addr_in;
                is_load_out   <= opcode_in == 7'b0000011;
                illegal_out   <= !dec_legal(opcode_in);
                rs1_q         <= rs1_addr_in;
                rs2_q         <= rs2_addr_in;
            end else if (fire) begin
                ex_valid_out <= 1'b0;
            end else begin
                if (snoop1)
                    op_a_out <= wb_result_in;
                if (snoop2)
                    rs2_out <= wb_result_in;
            end
        end
    end

`ifdef OPCTRL_TRACE_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            trace_imm_out <= '0;
            trace_fwd_out <= '0;
        end else if (accept) begin
            trace_imm_out <= imm_in;
            trace_fwd_out <= {rs1_mem, rs1_wb, rs2_mem, rs2_wb};
        end
    end
`endif
endmodule

// File: tb/tb_ex_operand_ctrl.sv
// tb_ex_operand_ctrl: scoreboard bench for ex_operand_ctrl (directed cases plus a random stream).
module tb_ex_operand_ctrl;
    logic        clk_in = 1'b0, rst_in = 1'b1, flush_in, id_valid_in, id_ready_out;
    logic [6:0]  opcode_in;
    logic [4:0]  rs1_addr_in, rs2_addr_in, rd_addr_in, mem_rd_in, wb_rd_in, rd_out;
    logic [11:0] imm_in, imm_value_out;
    logic [31:0] rs1_data_in, rs2_data_in, mem_result_in, wb_result_in, op_a_out, rs2_out;
    logic        mem_wr_en_in, wb_wr_en_in, ex_valid_out, ex_ready_in, imm_sel_out, is_load_out, illegal_out;
`ifdef OPCTRL_TRACE_EN
    logic [11:0] trace_imm_out;
    logic [3:0]  trace_fwd_out;
`endif

    typedef struct {
        logic        imm_sel;
        logic [11:0] imm;
        logic [31:0] op_a;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        is_load;
        logic        illegal;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0, n_bad = 0;
    logic       lu_m = 1'b0, last_ready;
    logic [4:0] lu_rd_m = '0;
    logic [6:0] ops[7] = '{7'b0010011, 7'b0000011, 7'b0100011, 7'b1100111, 7'b0110011, 7'b1100011, 7'b1111111};

    ex_operand_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in), .id_valid_in(id_valid_in),
        .id_ready_out(id_ready_out), .opcode_in(opcode_in), .rs1_addr_in(rs1_addr_in),
        .rs2_addr_in(rs2_addr_in), .rd_addr_in(rd_addr_in), .imm_in(imm_in),
        .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in), .mem_wr_en_in(mem_wr_en_in),
        .mem_rd_in(mem_rd_in), .mem_result_in(mem_result_in), .wb_wr_en_in(wb_wr_en_in),
        .wb_rd_in(wb_rd_in), .wb_result_in(wb_result_in), .ex_valid_out(ex_valid_out),
        .ex_ready_in(ex_ready_in), .imm_sel_out(imm_sel_out), .imm_value_out(imm_value_out),
        .op_a_out(op_a_out), .rs2_out(rs2_out), .rd_out(rd_out), .is_load_out(is_load_out),
`ifdef OPCTRL_TRACE_EN
        .illegal_out(illegal_out), .trace_imm_out(trace_imm_out), .trace_fwd_out(trace_fwd_out)
`else
        .illegal_out(illegal_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic imm_m(input logic [6:0] op);
        case (op)
            7'b0010011, 7'b0000011, 7'b0100011, 7'b1100111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic illegal_m(input logic [6:0] op);
        case (op)
            7'b0010011, 7'b0000011, 7'b0100011, 7'b1100111, 7'b0110011, 7'b1100011: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] fwd_m(input logic [4:0] a, input logic [31:0] rf);
        if (a == 0) return 32'h0;
        if (mem_wr_en_in && mem_rd_in == a) return mem_result_in;
        if (wb_wr_en_in && wb_rd_in == a) return wb_result_in;
        return rf;
    endfunction

    task automatic idle();
        id_valid_in = 0; flush_in = 0; ex_ready_in = 1; opcode_in = 0; imm_in = 0;
        rs1_addr_in = 0; rs2_addr_in = 0; rd_addr_in = 0; rs1_data_in = 0; rs2_data_in = 0;
        mem_wr_en_in = 0; mem_rd_in = 0; mem_result_in = 0; wb_wr_en_in = 0; wb_rd_in = 0; wb_result_in = 0;
    endtask

    task automatic instr(input logic [6:0] op, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] rd, input logic [11:0] imm);
        id_valid_in = 1; opcode_in = op; rs1_addr_in = a1; rs2_addr_in = a2; rd_addr_in = rd; imm_in = imm;
    endtask

    // one clock: model the cycle at the falling edge, return just after the rising edge
    task automatic step();
        exp_t e, h;
        logic lub, rdy_m, fire_m, new_lu;
        @(negedge clk_in);
        lub = lu_m && (rs1_addr_in == lu_rd_m || (!imm_m(opcode_in) && rs2_addr_in == lu_rd_m));
        rdy_m = (q.size() == 0 || ex_ready_in) && !lub && !flush_in;
        last_ready = id_ready_out;
        chk("id_ready", {31'b0, id_ready_out}, {31'b0, rdy_m});
        chk("ex_valid", {31'b0, ex_valid_out}, {31'b0, q.size() != 0});
        fire_m = q.size() != 0 && ex_ready_in;
        new_lu = 1'b0;
        if (fire_m) begin
            e = q.pop_front();
            chk("imm_sel", {31'b0, imm_sel_out}, {31'b0, e.imm_sel});
            chk("imm_value", {20'b0, imm_value_out}, {20'b0, e.imm});
            chk("op_a", op_a_out, e.op_a);
            chk("rs2", rs2_out, e.rs2);
            chk("rd", {27'b0, rd_out}, {27'b0, e.rd});
            chk("is_load", {31'b0, is_load_out}, {31'b0, e.is_load});
            chk("illegal", {31'b0, illegal_out}, {31'b0, e.illegal});
            new_lu = e.is_load && e.rd != 0;
        end
        if (flush_in) begin
            q.delete();
            lu_m = 1'b0;
        end else begin
            lu_m = new_lu;
            if (new_lu) lu_rd_m = e.rd;
            if (id_valid_in && rdy_m) begin
                h.imm_sel = imm_m(opcode_in); h.imm = imm_in; h.rd = rd_addr_in;
                h.op_a = fwd_m(rs1_addr_in, rs1_data_in); h.rs2 = fwd_m(rs2_addr_in, rs2_data_in);
                h.a1 = rs1_addr_in; h.a2 = rs2_addr_in;
                h.is_load = opcode_in == 7'b0000011; h.illegal = illegal_m(opcode_in);
                q.push_back(h);
            end else if (q.size() != 0 && !ex_ready_in && wb_wr_en_in) begin
                h = q[0];
                if (h.a1 != 0 && wb_rd_in == h.a1) h.op_a = wb_result_in;
                if (h.a2 != 0 && wb_rd_in == h.a2) h.rs2 = wb_result_in;
                q[0] = h;
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_ready", {31'b0, id_ready_out}, 32'h0);
        chk("rst_valid", {31'b0, ex_valid_out}, 32'h0);
        chk("rst_imm_sel", {31'b0, imm_sel_out}, 32'h0);
        chk("rst_op_a", op_a_out, 32'h0);
        rst_in = 0;

        // addi x1,x0,5
        instr(7'b0010011, 0, 0, 1, 12'h005); rs1_data_in = 32'h999;
        step();
        idle();
        chk("addi_imm_sel", {31'b0, imm_sel_out}, 32'h1);
        chk("addi_imm", {20'b0, imm_value_out}, 32'h005);
        step();

        // add x3,x1,x2 with MEM and WB both hitting x1
        instr(7'b0110011, 1, 2, 3, 0); rs1_data_in = 32'h5; rs2_data_in = 32'h77;
        mem_wr_en_in = 1; mem_rd_in = 1; mem_result_in = 32'h11;
        wb_wr_en_in = 1; wb_rd_in = 1; wb_result_in = 32'h22;
        step();
        idle();
        chk("mem_prio", op_a_out, 32'h11);
        step();

        // lw x5 then dependent add x6,x5,x0
        instr(7'b0000011, 0, 0, 5, 12'h010);
        step();
        idle();
        step();
        instr(7'b0110011, 5, 0, 6, 0);
        step();
        chk("lu_block", {31'b0, last_ready}, 32'h0);
        step();
        chk("lu_accept", {31'b0, last_ready}, 32'h1);
        idle();
        step();

        // WB snoop into stalled rs2=x7
        instr(7'b0110011, 0, 7, 8, 0); rs2_data_in = 32'h1; ex_ready_in = 0;
        step();
        idle(); ex_ready_in = 0; wb_wr_en_in = 1; wb_rd_in = 7; wb_result_in = 32'hDEAD;
        step();
        idle();
        chk("snoop_rs2", rs2_out, 32'hDEAD);
        step();

        // x0 source ignores MEM forward of x0
        instr(7'b0110011, 0, 0, 9, 0); rs1_data_in = 32'h1234; rs2_data_in = 32'h5678;
        mem_wr_en_in = 1; mem_rd_in = 0; mem_result_in = 32'hFFFF;
        step();
        idle();
        chk("x0_op_a", op_a_out, 32'h0);
        step();

        // flush with held entry and a waiting ID instruction
        instr(7'b0010011, 1, 0, 2, 12'h7FF); ex_ready_in = 0;
        step();
        instr(7'b0010011, 1, 0, 3, 12'h001); ex_ready_in = 0; flush_in = 1;
        step();
        chk("flush_ready", {31'b0, last_ready}, 32'h0);
        idle();
        chk("flush_valid", {31'b0, ex_valid_out}, 32'h0);
        step();

        // asynchronous reset while an entry is held
        instr(7'b0110011, 0, 0, 4, 0); ex_ready_in = 0;
        step();
        idle(); ex_ready_in = 0;
        #2 rst_in = 1;
        #1;
        chk("arst_valid", {31'b0, ex_valid_out}, 32'h0);
        chk("arst_rd", {27'b0, rd_out}, 32'h0);
        q.delete(); lu_m = 1'b0;
        @(posedge clk_in);
        #1 rst_in = 0;

        // random stream: back-to-back, stalls, load-use, snoops, flushes
        for (int i = 0; i < 400; i++) begin
            id_valid_in = $urandom_range(0, 3) != 0;
            opcode_in = ops[$urandom_range(0, 6)];
            rs1_addr_in = 5'($urandom_range(0, 3)); rs2_addr_in = 5'($urandom_range(0, 3));
            rd_addr_in = 5'($urandom_range(0, 3)); imm_in = 12'($urandom);
            rs1_data_in = $urandom; rs2_data_in = $urandom;
            mem_wr_en_in = $urandom_range(0, 1) != 0; mem_rd_in = 5'($urandom_range(0, 3)); mem_result_in = $urandom;
            wb_wr_en_in = $urandom_range(0, 1) != 0; wb_rd_in = 5'($urandom_range(0, 3)); wb_result_in = $urandom;
            ex_ready_in = $urandom_range(0, 3) != 0;
            flush_in = $urandom_range(0, 15) == 0;
            step();
        end
        idle();
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
